// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences datapath selects/enables, runs the memory
// request/ready handshake, reports retirement and illegal encodings.
//
// state  | meaning
// FETCH  | read instruction at pc, pc <= pc+4 when memory is ready
// DECODE | register read, branch target into ALUOut, dispatch on opcode
// MEMADR | lw/sw effective address
// MEMRD  | lw data read, wait for mem_ready
// MEMWB  | lw write-back to rt
// MEMWR  | sw data write, wait for mem_ready
// EXEC   | R-type ALU op from funct
// ALUWB  | R-type write-back to rd
// BRANCH | beq compare, pc <= ALUOut on Zero
// ADDIEX | addi ALU op
// ADDIWB | addi write-back to rt
// JUMP   | pc <= jump target
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCEn,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUControl,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     state, next_state;
    logic       funct_ok;
    logic [3:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= next_state;
            if (instr_done) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  next_state = mem_ready ? MEMWB : MEMRD;
            MEMWR:  next_state = mem_ready ? FETCH : MEMWR;
            EXEC:   next_state = funct_ok ? ALUWB : FETCH;
            ADDIEX: next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCEn       = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b0000;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = mem_ready;
                PCEn       = mem_ready;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                illegal    = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
            end
            MEMADR, ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
                illegal    = !funct_ok;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                PCEn       = Zero;
                instr_done = 1'b1;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                PCEn       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset must abandon any in-flight access without a partial write.
        if (!reset) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCEn       = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule
